// File: rtl/serial_sum_collector.sv
// serial_sum_collector
// Collects the registered S1/Cout stream of the pipelined 1-bit full adder into
// a WIDTH-bit word (LSB first) and presents it, with the final carry, on a
// valid/ready handshake. The in_valid/in_last qualifiers are aligned with the
// adder operands and are delayed LATENCY cycles here to meet the S1/Cout stream.
//
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   in_valid, in_last    operand-aligned bit qualifiers
//   S1, Cout             adder sum / carry bits (LATENCY cycles after operands)
//   res_data, res_carry  collected word and carry of its last bit
//   res_valid, res_ready result handshake
//   busy                 partial word being collected
//   err_overrun, err_clr sticky overrun flag (bit arrived while holding) / clear
//   res_parity           XOR of res_data (only when SUM_PARITY_EN is defined)
//
// Optional feature: define SUM_PARITY_EN to add res_parity.
module serial_sum_collector #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             S1,
    input  logic             Cout,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             err_overrun,
`ifdef SUM_PARITY_EN
    output logic             res_parity,
`endif
    input  logic             err_clr
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LATENCY-1:0] dv_sr, dl_sr;
    logic               dv, dl;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [WIDTH-1:0]   data_d;
    logic               carry_d;
    logic               err_d;
    logic               start;
    logic               overrun;

    assign dv = dv_sr[LATENCY-1];
    assign dl = dl_sr[LATENCY-1];

    // Qualifier delay lines matching the adder pipeline depth
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dv_sr <= '0;
            dl_sr <= '0;
        end else begin
            dv_sr[0] <= in_valid;
            dl_sr[0] <= in_last;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                dv_sr[i] <= dv_sr[i-1];
                dl_sr[i] <= dl_sr[i-1];
            end
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = res_data;
        carry_d  = res_carry;
        start    = 1'b0;
        overrun  = 1'b0;

        case (state_q)
            IDLE: start = dv;
            COLLECT: begin
                if (dv) begin
                    shadow_d[cnt_q] = S1;
                    if (dl || (cnt_q == CW'(WIDTH - 1))) begin
                        data_d  = shadow_d;
                        carry_d = Cout;
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                    start   = dv;
                end else if (dv) begin
                    overrun = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // First bit of a word, either from IDLE or in the handshake cycle
        if (start) begin
            shadow_d    = '0;
            shadow_d[0] = S1;
            if (dl) begin
                data_d  = WIDTH'(S1);
                carry_d = Cout;
                state_d = HOLD;
                cnt_d   = '0;
            end else begin
                state_d = COLLECT;
                cnt_d   = CW'(1);
            end
        end

        // A new overrun wins over a simultaneous clear
        err_d = (err_overrun & ~err_clr) | overrun;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            res_data    <= '0;
            res_carry   <= 1'b0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            err_overrun <= 1'b0;
`ifdef SUM_PARITY_EN
            res_parity  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            res_data    <= data_d;
            res_carry   <= carry_d;
            res_valid   <= (state_d == HOLD);
            busy        <= (state_d == COLLECT);
            err_overrun <= err_d;
`ifdef SUM_PARITY_EN
            res_parity  <= ^data_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_sum_collector.sv
// Directed self-checking bench for serial_sum_collector (WIDTH=4, LATENCY=2).
// A two-stage register pair stands in for the adder pipeline so S1/Cout trail
// the operand-aligned qualifiers by two cycles.
module tb_serial_sum_collector;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned LATENCY = 2;

    logic             clk;
    logic             rstn;
    logic             in_valid;
    logic             in_last;
    logic             S1;
    logic             Cout;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_valid;
    logic             res_ready;
    logic             busy;
    logic             err_overrun;
    logic             err_clr;
`ifdef SUM_PARITY_EN
    logic             res_parity;
`endif

    logic a_s, a_c, s_d1, c_d1;

    int n_chk = 0;
    int n_err = 0;

    serial_sum_collector #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .S1          (S1),
        .Cout        (Cout),
        .res_data    (res_data),
        .res_carry   (res_carry),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy),
        .err_overrun (err_overrun),
`ifdef SUM_PARITY_EN
        .res_parity  (res_parity),
`endif
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder pipeline stand-in: sum/carry emerge two cycles after the operands
    initial begin
        s_d1 = 1'b0; c_d1 = 1'b0; S1 = 1'b0; Cout = 1'b0;
    end
    always @(posedge clk) begin
        s_d1 <= a_s;
        c_d1 <= a_c;
        S1   <= s_d1;
        Cout <= c_d1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one operand-aligned bit (s = its sum, c = its carry) for a cycle
    task automatic drive(input logic v, input logic l, input logic s, input logic c);
        in_valid = v;
        in_last  = l;
        a_s      = s;
        a_c      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_last = 1'b0; a_s = 1'b0; a_c = 1'b0;
        res_ready = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_data", 32'(res_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_overrun), 32'd0);
`ifdef SUM_PARITY_EN
        check("rst_par", 32'(res_parity), 32'd0);
`endif
        rstn = 1'b1;
        idle(1);

        // Contiguous 4-bit word 0,0,0,1
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 1, 1, 0);
        idle(1);
        check("t1_valid_early", 32'(res_valid), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        idle(1);
        check("t1_valid", 32'(res_valid), 32'd1);
        check("t1_data", 32'(res_data), 32'h8);
        check("t1_carry", 32'(res_carry), 32'd0);
        check("t1_busy_hold", 32'(busy), 32'd0);
`ifdef SUM_PARITY_EN
        check("t1_par", 32'(res_parity), 32'd1);
`endif
        res_ready = 1'b1;
        idle(1);
        check("t1_hs", 32'(res_valid), 32'd0);
        res_ready = 1'b0;

        // Short word 1,1 with final carry
        drive(1, 0, 1, 0);
        drive(1, 1, 1, 1);
        idle(2);
        check("t2_valid", 32'(res_valid), 32'd1);
        check("t2_data", 32'(res_data), 32'h3);
        check("t2_carry", 32'(res_carry), 32'd1);
`ifdef SUM_PARITY_EN
        check("t2_par", 32'(res_parity), 32'd0);
`endif

        // Backpressure, then handshake coinciding with bit 0 of word 1,0,1,1
        idle(3);
        check("t3_stable_a", 32'(res_data), 32'h3);
        drive(1, 0, 1, 0);
        drive(1, 0, 0, 0);
        check("t3_stable_b", 32'(res_data), 32'h3);
        check("t3_valid_held", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        drive(1, 0, 1, 0);
        check("t3_hs_valid", 32'(res_valid), 32'd0);
        check("t3_hs_busy", 32'(busy), 32'd1);
        check("t3_hs_err", 32'(err_overrun), 32'd0);
        res_ready = 1'b0;
        drive(1, 1, 1, 0);
        idle(2);
        check("t3_valid", 32'(res_valid), 32'd1);
        check("t3_data", 32'(res_data), 32'hD);
        check("t3_err", 32'(err_overrun), 32'd0);

        // Overrun while holding, then simultaneous set/clear, then clear
        drive(1, 0, 0, 0);
        idle(2);
        check("t4_err_set", 32'(err_overrun), 32'd1);
        check("t4_data", 32'(res_data), 32'hD);
        check("t4_valid", 32'(res_valid), 32'd1);
        drive(1, 0, 0, 0);
        idle(1);
        err_clr = 1'b1;
        idle(1);
        check("t4_set_wins", 32'(err_overrun), 32'd1);
        idle(1);
        check("t4_clr", 32'(err_overrun), 32'd0);
        err_clr = 1'b0;
        res_ready = 1'b1;
        idle(1);
        check("t4_hs", 32'(res_valid), 32'd0);
        res_ready = 1'b0;

        // Gapped word 0,0,0,1 with three idle cycles between bits
        drive(1, 0, 0, 0);
        idle(3);
        check("t5_busy_a", 32'(busy), 32'd1);
        drive(1, 0, 0, 0);
        idle(3);
        check("t5_busy_b", 32'(busy), 32'd1);
        drive(1, 0, 0, 0);
        idle(3);
        check("t5_busy_c", 32'(busy), 32'd1);
        check("t5_no_valid", 32'(res_valid), 32'd0);
        drive(1, 1, 1, 0);
        idle(2);
        check("t5_valid", 32'(res_valid), 32'd1);
        check("t5_data", 32'(res_data), 32'h8);
        res_ready = 1'b1;
        idle(1);

        // Implicit last at WIDTH bits, then a 1-bit word back to back
        drive(1, 0, 1, 0);
        drive(1, 0, 1, 0);
        drive(1, 0, 1, 0);
        drive(1, 0, 1, 1);
        drive(1, 1, 1, 0);
        idle(1);
        check("t6_valid_a", 32'(res_valid), 32'd1);
        check("t6_data_a", 32'(res_data), 32'hF);
        check("t6_carry_a", 32'(res_carry), 32'd1);
        idle(1);
        check("t6_valid_b", 32'(res_valid), 32'd1);
        check("t6_data_b", 32'(res_data), 32'h1);
        check("t6_carry_b", 32'(res_carry), 32'd0);
`ifdef SUM_PARITY_EN
        check("t6_par", 32'(res_parity), 32'd1);
`endif
        idle(1);
        check("t6_hs", 32'(res_valid), 32'd0);
        res_ready = 1'b0;

        // Reset mid-word, then a fresh word 1,0,1,0
        drive(1, 0, 1, 0);
        drive(1, 0, 1, 0);
        idle(1);
        check("t7_busy_pre", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_valid", 32'(res_valid), 32'd0);
        check("t7_rst_data", 32'(res_data), 32'd0);
        check("t7_rst_carry", 32'(res_carry), 32'd0);
        check("t7_rst_err", 32'(err_overrun), 32'd0);
        idle(2);
        rstn = 1'b1;
        idle(1);
        drive(1, 0, 1, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 1, 0);
        drive(1, 1, 0, 0);
        idle(2);
        check("t7_valid", 32'(res_valid), 32'd1);
        check("t7_data", 32'(res_data), 32'h5);
        check("t7_carry", 32'(res_carry), 32'd0);
        check("t7_err", 32'(err_overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_sum_collector.md
Name: serial_sum_collector

Overview:
Downstream stage of the pipelined 1-bit full adder. Consumes the registered S1/Cout stream that the adder produces two cycles after its operand bits. Packs the sum bits LSB-first into a WIDTH-bit result word, captures the final carry, and presents the word on a valid/ready handshake. Tracks the adder's pipeline latency internally, so upstream drives only the qualifiers aligned with the operand bits.

Parameters:
WIDTH, 8, result word width in bits (>=2)
LATENCY, 2, cycles from operand bits at adder input to S1/Cout valid (>=1)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  operand bit presented to adder this cycle (aligned with A1/B1/Cin)
in_last  in  1  operand bit is MSB of current word (aligned with in_valid)
S1  in  1  adder sum bit
Cout  in  1  adder carry bit
res_data  out  WIDTH  collected sum word, bit 0 = first bit received
res_carry  out  1  Cout captured with the last bit of the word
res_valid  out  1  result word available
res_ready  in  1  consumer accepts result
busy  out  1  partial word being collected (state COLLECT)
err_overrun  out  1  sticky: a sum bit arrived while HOLD and no handshake
err_clr  in  1  synchronous clear of err_overrun

Behaviour:
- Reset (async, rstn=0): state IDLE; LATENCY-deep valid/last delay lines cleared; bit counter=0; res_data=0, res_carry=0, res_valid=0, busy=0, err_overrun=0.
- Delay line: dv/dl = in_valid/in_last delayed exactly LATENCY cycles; S1/Cout sampled only when dv=1.
- States: IDLE (no bits held), COLLECT (1..WIDTH-1 bits held), HOLD (word complete, res_valid=1).
- IDLE, dv=1: S1 -> shadow bit 0, cnt=1; if dl=1 -> HOLD (WIDTH-1 upper bits zero), else COLLECT.
- COLLECT, dv=1: S1 -> shadow bit cnt, cnt++; word ends when dl=1 or cnt==WIDTH-1 (implicit last). On end: res_data<=shadow incl. this bit, unfilled upper bits zero; res_carry<=Cout; res_valid<=1 next cycle; -> HOLD; cnt=0.
- COLLECT, dv=0: hold state (gaps allowed, no timeout).
- HOLD: res_data/res_carry stable while res_valid=1 and res_ready=0.
- Handshake: res_valid & res_ready -> res_valid=0 next cycle; -> IDLE, or consume dv bit same cycle as bit 0 of the next word (-> COLLECT/HOLD as above). Zero-bubble back-to-back throughput.
- Overrun: dv=1 in HOLD with res_ready=0 -> bit dropped, err_overrun<=1, word unchanged. err_clr=1 clears; simultaneous set and clear -> set wins.
- busy = (state==COLLECT).
- Reset mid-word or mid-HOLD: everything discarded; in-flight delay-line bits lost.

Optional Feature:
Macro SUM_PARITY_EN. Defined: adds output res_parity (1 bit) = XOR of all WIDTH bits of res_data, registered with res_data, reset 0, stable under the same HOLD rules. Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- WIDTH=4, LATENCY=2: in_valid=1 x4, in_last on 4th; S1 = 0,0,0,1 and Cout=0 on final bit, driven 2 cycles later -> res_data=4'b1000, res_carry=0, res_valid rises 1 cycle after final dv.
- Short word: 2 bits, in_last on 2nd, S1 = 1,1, final Cout=1 -> res_data=4'b0011, res_carry=1.
- Backpressure: res_ready=0 for 5 cycles after completion -> res_data stable. Then res_ready=1 with new dv same cycle -> handshake, new bit lands in bit 0, err_overrun stays 0.
- Overrun: res_ready=0, one extra dv in HOLD -> err_overrun=1, res_data unchanged; err_clr pulse -> 0.
- Gapped input: 4 bits with 3-cycle gaps -> word identical to contiguous case; busy=1 throughout collection.
- rstn low mid-word after 2 bits, then a fresh 4-bit word S1 = 1,0,1,0 -> res_data=4'b0101, no stale bits; all outputs 0 during reset.
